// File: rtl/ysyx_24110015_pkg.sv
// Shared encodings and state type for the ysyx_24110015 instruction cache.
// Refill mode is selected by YSYX_24110015_ICACHE_BURST_EN in the cache top.
package ysyx_24110015_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam int         AXI_ID_W       = 4;

   typedef enum logic [2:0] {
      IC_IDLE,
      IC_LOOKUP,
      IC_AR,
      IC_R,
      IC_RESP
   } icache_state_t;

endpackage

// File: rtl/ysyx_24110015_axi_if.sv
// AXI4 bundle (32-bit address/data) between the IFU cache and the arbiter.
// master drives requests, slave drives responses.
interface axi_if;
   import ysyx_24110015_pkg::*;

   logic                awvalid;
   logic                awready;
   logic [31:0]         awaddr;
   logic [AXI_ID_W-1:0] awid;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;

   logic                wvalid;
   logic                wready;
   logic [31:0]         wdata;
   logic [3:0]          wstrb;
   logic                wlast;

   logic                bvalid;
   logic                bready;
   logic [1:0]          bresp;
   logic [AXI_ID_W-1:0] bid;

   logic                arvalid;
   logic                arready;
   logic [31:0]         araddr;
   logic [AXI_ID_W-1:0] arid;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;

   logic                rvalid;
   logic                rready;
   logic [31:0]         rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic [AXI_ID_W-1:0] rid;

   modport master (
      output awvalid, awaddr, awid, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bresp, bid,
      output bready,
      output arvalid, araddr, arid, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rdata, rresp, rlast, rid,
      output rready
   );

   modport slave (
      input  awvalid, awaddr, awid, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bresp, bid,
      input  bready,
      input  arvalid, araddr, arid, arlen, arsize, arburst,
      output arready,
      output rvalid, rdata, rresp, rlast, rid,
      input  rready
   );

endinterface

// File: rtl/ysyx_24110015_icache_array.sv
// Register-based tag/valid/data storage with combinational read,
// word write, tag/valid set and global invalidate.
module ysyx_24110015_icache_array #(
   parameter  int NUM_SETS    = 16,
   parameter  int BLOCK_WORDS = 4,
   parameter  int TAG_W       = 24,
   localparam int IDX_W       = $clog2(NUM_SETS),
   localparam int CNT_W       = $clog2(BLOCK_WORDS)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [IDX_W-1:0]             rd_index,
   output logic                         rd_valid,
   output logic [TAG_W-1:0]             rd_tag,
   output logic [BLOCK_WORDS-1:0][31:0] rd_line,
   input  logic                         wr_en,
   input  logic [IDX_W-1:0]             wr_index,
   input  logic [CNT_W-1:0]             wr_word,
   input  logic [31:0]                  wr_data,
   input  logic                         set_en,
   input  logic [IDX_W-1:0]             set_index,
   input  logic [TAG_W-1:0]             set_tag,
   input  logic                         set_valid,
   input  logic                         clear_all
);

   logic [NUM_SETS-1:0]          valid_q, valid_d;
   logic [TAG_W-1:0]             tag_q  [NUM_SETS];
   logic [TAG_W-1:0]             tag_d  [NUM_SETS];
   logic [BLOCK_WORDS-1:0][31:0] data_q [NUM_SETS];
   logic [BLOCK_WORDS-1:0][31:0] data_d [NUM_SETS];

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_line  = data_q[rd_index];

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (set_en) begin
         valid_d[set_index] = set_valid;
         tag_d[set_index]   = set_tag;
      end
      if (wr_en) begin
         data_d[wr_index][wr_word] = wr_data;
      end
      if (clear_all) begin
         valid_d = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Payload needs no reset: it is only read behind a valid bit.
   always_ff @(posedge clock) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule

// File: rtl/ysyx_24110015_icache.sv
// Direct-mapped read-only I-cache with AXI4 line refill.
// YSYX_24110015_ICACHE_BURST_EN: one INCR burst per miss, else single beats.
module ysyx_24110015_icache
   import ysyx_24110015_pkg::*;
#(
   parameter int NUM_SETS    = 16,
   parameter int BLOCK_WORDS = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_inst,
   output logic        resp_err,
   input  logic        flush,
   input  logic        fence_i,
   axi_if.master       axi
);

`ifdef YSYX_24110015_ICACHE_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   localparam int OFF_W = $clog2(BLOCK_WORDS * 4);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int CNT_W = $clog2(BLOCK_WORDS);
   localparam int TAG_W = 32 - OFF_W - IDX_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_WORDS - 1);

   icache_state_t state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             discard_q, discard_d;
   logic             fence_q, fence_d;
   logic [31:0]      inst_q, inst_d;

   logic [IDX_W-1:0]             idx;
   logic [TAG_W-1:0]             tag;
   logic [CNT_W-1:0]             woff;
   logic                         rd_valid;
   logic [TAG_W-1:0]             rd_tag;
   logic [BLOCK_WORDS-1:0][31:0] rd_line;
   logic                         hit;
   logic                         beat_bad;
   logic                         last_beat;
   logic                         ar_valid;
   logic                         r_ready;
   logic                         wr_en;
   logic                         set_en;
   logic                         set_valid;
   logic                         clear_all;

   assign idx  = addr_q[OFF_W +: IDX_W];
   assign tag  = addr_q[31 -: TAG_W];
   assign woff = addr_q[OFF_W-1:2];
   assign hit  = rd_valid && (rd_tag == tag);

   assign beat_bad  = axi.rresp != AXI_RESP_OKAY;
   assign last_beat = BURST ? axi.rlast : (cnt_q == LAST_CNT);

   ysyx_24110015_icache_array #(
      .NUM_SETS    (NUM_SETS),
      .BLOCK_WORDS (BLOCK_WORDS),
      .TAG_W       (TAG_W)
   ) u_array (
      .clock     (clock),
      .reset     (reset),
      .rd_index  (idx),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_line   (rd_line),
      .wr_en     (wr_en),
      .wr_index  (idx),
      .wr_word   (cnt_q),
      .wr_data   (axi.rdata),
      .set_en    (set_en),
      .set_index (idx),
      .set_tag   (tag),
      .set_valid (set_valid),
      .clear_all (clear_all)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      discard_d  = discard_q;
      fence_d    = fence_q;
      inst_d     = inst_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_inst  = '0;
      resp_err   = 1'b0;
      ar_valid   = 1'b0;
      r_ready    = 1'b0;
      wr_en      = 1'b0;
      set_en     = 1'b0;
      set_valid  = 1'b0;
      clear_all  = 1'b0;

      if (fence_i && state_q != IC_IDLE) begin
         fence_d = 1'b1;
      end

      unique case (state_q)
         IC_IDLE: begin
            clear_all = fence_i || fence_q;
            fence_d   = 1'b0;
            req_ready = !(fence_i || fence_q);
            if (req_valid && req_ready) begin
               addr_d  = req_addr;
               state_d = IC_LOOKUP;
            end
         end
         IC_LOOKUP: begin
            if (flush) begin
               state_d = IC_IDLE;
            end else if (hit) begin
               resp_valid = 1'b1;
               resp_inst  = rd_line[woff];
               if (resp_ready) state_d = IC_IDLE;
            end else begin
               state_d   = IC_AR;
               cnt_d     = '0;
               err_d     = 1'b0;
               discard_d = 1'b0;
            end
         end
         IC_AR: begin
            ar_valid = 1'b1;
            if (flush) discard_d = 1'b1;
            if (axi.arready) state_d = IC_R;
         end
         IC_R: begin
            r_ready = 1'b1;
            if (flush) discard_d = 1'b1;
            if (axi.rvalid) begin
               wr_en = 1'b1;
               err_d = err_q || beat_bad;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == woff) inst_d = axi.rdata;
               if (last_beat) begin
                  // A flush on the final beat still skips RESP.
                  set_en    = 1'b1;
                  set_valid = !(err_q || beat_bad);
                  cnt_d     = '0;
                  discard_d = 1'b0;
                  state_d   = (discard_q || flush) ? IC_IDLE
                                                   : IC_RESP;
               end else if (!BURST) begin
                  state_d = IC_AR;
               end
            end
         end
         IC_RESP: begin
            if (flush) begin
               state_d = IC_IDLE;
            end else begin
               resp_valid = 1'b1;
               resp_inst  = inst_q;
               resp_err   = err_q;
               if (resp_ready) state_d = IC_IDLE;
            end
         end
         default: state_d = IC_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IC_IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         discard_q <= 1'b0;
         fence_q   <= 1'b0;
         inst_q    <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         discard_q <= discard_d;
         fence_q   <= fence_d;
         inst_q    <= inst_d;
      end
   end

   assign axi.arvalid = ar_valid;
   assign axi.araddr  = BURST ? {addr_q[31:OFF_W], {OFF_W{1'b0}}}
                              : {addr_q[31:OFF_W], cnt_q, 2'b00};
   assign axi.arlen   = BURST ? 8'(BLOCK_WORDS - 1) : 8'd0;
   assign axi.arid    = '0;
   assign axi.arsize  = AXI_SIZE_4B;
   assign axi.arburst = AXI_BURST_INCR;
   assign axi.rready  = r_ready;

   assign axi.awvalid = 1'b0;
   assign axi.awaddr  = '0;
   assign axi.awid    = '0;
   assign axi.awlen   = '0;
   assign axi.awsize  = '0;
   assign axi.awburst = '0;
   assign axi.wvalid  = 1'b0;
   assign axi.wdata   = '0;
   assign axi.wstrb   = '0;
   assign axi.wlast   = 1'b0;
   assign axi.bready  = 1'b1;

   logic unused_sig;
   assign unused_sig = ^{axi.awready, axi.wready, axi.bvalid,
                         axi.bresp, axi.bid, axi.rid, addr_q[1:0]};

endmodule

// File: tb/tb_ysyx_24110015_icache.sv
// Scoreboard bench for ysyx_24110015_icache: AXI memory model on negedges,
// expected fetch results queued at request, compared at response.
module tb_ysyx_24110015_icache;

`ifdef YSYX_24110015_ICACHE_BURST_EN
   localparam int AR_PER_MISS = 1;
   localparam int EXP_LEN     = 3;
`else
   localparam int AR_PER_MISS = 4;
   localparam int EXP_LEN     = 0;
`endif
   localparam int LIM = 300;

   typedef struct {
      logic [31:0] inst;
      logic        err;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_inst;
   logic        resp_err;
   logic        flush = 1'b0;
   logic        fence_i = 1'b0;

   axi_if axi_bus ();

   ysyx_24110015_icache dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_inst  (resp_inst),
      .resp_err   (resp_err),
      .flush      (flush),
      .fence_i    (fence_i),
      .axi        (axi_bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ar_cnt   = 0;
   int resp_cnt = 0;
   int resp_cyc = 0;
   exp_t exp_q[$];
   logic [31:0] ar_addr_log[$];
   logic [7:0]  ar_len_log[$];
   bit          err_on = 1'b0;
   logic [31:0] err_addr = '0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[31:4] == 28'h300_0000)
         return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
      return {a[31:2], 2'b01} ^ 32'hC0DE_0000;
   endfunction

   // AXI slave: outputs change on negedge, handshakes predicted just after.
   initial begin : slave
      bit          busy, pred_ar, pred_r;
      logic [31:0] base, p_addr;
      int          len, beat, p_len;
      logic [31:0] a;
      busy = 0; pred_ar = 0; pred_r = 0;
      base = '0; p_addr = '0; len = 0; beat = 0; p_len = 0;
      axi_bus.awready = 1'b0;
      axi_bus.wready  = 1'b0;
      axi_bus.bvalid  = 1'b0;
      axi_bus.bresp   = 2'b00;
      axi_bus.bid     = '0;
      axi_bus.rid     = '0;
      axi_bus.arready = 1'b0;
      axi_bus.rvalid  = 1'b0;
      axi_bus.rdata   = '0;
      axi_bus.rresp   = 2'b00;
      axi_bus.rlast   = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            busy = 0; pred_ar = 0; pred_r = 0;
         end else begin
            if (pred_ar) begin
               busy = 1; base = p_addr; len = p_len; beat = 0;
            end
            if (pred_r) begin
               if (beat == len) busy = 0;
               beat++;
            end
         end
         a = base + 32'(4 * beat);
         axi_bus.arready = !busy && !reset;
         axi_bus.rvalid  = busy;
         axi_bus.rdata   = busy ? mem_word(a) : '0;
         axi_bus.rresp   = (busy && err_on && a == err_addr) ? 2'b10 : 2'b00;
         axi_bus.rlast   = busy && (beat == len);
         #1;
         pred_ar = axi_bus.arvalid && axi_bus.arready;
         pred_r  = axi_bus.rvalid && axi_bus.rready;
         p_addr  = axi_bus.araddr;
         p_len   = int'(axi_bus.arlen);
         if (pred_ar) begin
            ar_cnt++;
            ar_addr_log.push_back(axi_bus.araddr);
            ar_len_log.push_back(axi_bus.arlen);
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         #2;
         if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
               chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("resp_inst", resp_inst, e.inst);
               chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            end
            resp_cnt++;
            resp_cyc = cyc;
         end
      end
   end

   task automatic issue(input logic [31:0] a);
      int k;
      @(negedge clock);
      req_valid = 1'b1;
      req_addr  = a;
      #1;
      k = 0;
      while (!req_ready && k < LIM) begin
         @(negedge clock);
         #1;
         k++;
      end
      chk("req_accept", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic fetch(input logic [31:0] a, input bit miss,
                        input bit err);
      int k, ar0, r0, c0;
      issue(a);
      ar0 = ar_cnt;
      r0  = resp_cnt;
      c0  = cyc;
      exp_q.push_back('{inst: mem_word(a), err: err});
      @(negedge clock);
      req_valid = 1'b0;
      k = 0;
      while (resp_cnt == r0 && k < LIM) begin
         @(negedge clock);
         #3;
         k++;
      end
      chk("resp_seen", resp_cnt - r0, 32'd1);
      chk("ar_count", ar_cnt - ar0, miss ? AR_PER_MISS : 0);
      if (miss && ar_addr_log.size() > ar0) begin
         chk("araddr", ar_addr_log[ar0], a & ~32'hF);
         chk("arlen", {24'd0, ar_len_log[ar0]}, EXP_LEN);
      end
      if (!miss) chk("hit_latency", resp_cyc - c0, 32'd1);
   endtask

   task automatic wait_rready(input string tag);
      int k;
      k = 0;
      #1;
      while (!axi_bus.rready && k < LIM) begin
         @(negedge clock);
         #1;
         k++;
      end
      chk(tag, {31'd0, axi_bus.rready}, 32'd1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int k, r0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_inst", resp_inst, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_arvalid", {31'd0, axi_bus.arvalid}, 32'd0);
      chk("rst_rready", {31'd0, axi_bus.rready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

      // cold miss then hits in the same line
      fetch(32'h3000_0000, 1, 0);
      fetch(32'h3000_0004, 0, 0);
      fetch(32'h3000_000C, 0, 0);

      // conflict eviction on index 0
      fetch(32'h3000_0100, 1, 0);
      fetch(32'h3000_0000, 1, 0);

      // fence_i in IDLE
      @(negedge clock);
      fence_i = 1'b1;
      #1;
      chk("fence_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clock);
      fence_i = 1'b0;
      fetch(32'h3000_0000, 1, 0);

      // flush during refill: no response, line still filled
      r0 = resp_cnt;
      issue(32'h3000_0040);
      @(negedge clock);
      req_valid = 1'b0;
      wait_rready("flush_reach_r");
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      k = 0;
      #1;
      while (!(req_ready && !axi_bus.rvalid) && k < LIM) begin
         @(negedge clock);
         #1;
         k++;
      end
      chk("flush_idle", {31'd0, req_ready}, 32'd1);
      repeat (2) @(negedge clock);
      chk("flush_no_resp", resp_cnt - r0, 32'd0);
      fetch(32'h3000_0044, 0, 0);

      // error beat on word 2: reported, line stays invalid
      err_addr = 32'h3000_0088;
      err_on   = 1'b1;
      fetch(32'h3000_0080, 1, 1);
      fetch(32'h3000_0084, 1, 1);
      err_on   = 1'b0;
      fetch(32'h3000_0080, 1, 0);
      fetch(32'h3000_008C, 0, 0);

      // backpressure on a hit
      @(negedge clock);
      resp_ready = 1'b0;
      issue(32'h3000_0004);
      r0 = resp_cnt;
      exp_q.push_back('{inst: mem_word(32'h3000_0004), err: 1'b0});
      @(negedge clock);
      req_addr = 32'h3000_0008;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_valid", {31'd0, resp_valid}, 32'd1);
         chk("bp_inst", resp_inst, 32'h0000_0022);
         chk("bp_no_accept", {31'd0, req_ready}, 32'd0);
         @(negedge clock);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      k = 0;
      while (resp_cnt == r0 && k < LIM) begin
         @(negedge clock);
         #3;
         k++;
      end
      chk("bp_resp_seen", resp_cnt - r0, 32'd1);

      // reset in the middle of a refill
      issue(32'h3000_0200);
      @(negedge clock);
      req_valid = 1'b0;
      wait_rready("rst_reach_r");
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst2_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst2_arvalid", {31'd0, axi_bus.arvalid}, 32'd0);
      fetch(32'h3000_0200, 1, 0);
      fetch(32'h3000_0044, 1, 0);
      fetch(32'h3000_0204, 0, 0);

      repeat (3) @(negedge clock);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_24110015_icache.md
# ysyx_24110015_icache

Direct-mapped, read-only instruction cache between the IFU fetch port and the IFU-side AXI master that feeds the AXI arbiter. It serves instruction fetches from local storage on a hit. On a miss it refills a whole line over AXI4, invalidates on `fence.i`, and drops responses squashed by a control hazard.

## Interface
Parameters:
- `NUM_SETS`, default 16: number of lines; power of two.
- `BLOCK_WORDS`, default 4: 32-bit words per line; power of two, at least 2.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  IFU fetch request valid.
- `req_ready`  out  1  cache can accept a request.
- `req_addr`  in  32  fetch address; bits [1:0] are ignored.
- `resp_valid`  out  1  instruction valid.
- `resp_ready`  in  1  IFU accepts the instruction.
- `resp_inst`  out  32  instruction word.
- `resp_err`  out  1  refill returned a non-OKAY `rresp`.
- `flush`  in  1  control hazard; squash the pending response.
- `fence_i`  in  1  invalidate all lines.
- `axi`  master  `axi_if`  refill port to the arbiter's IFU input.

## Operation
- Address split:
  - offset = log2(BLOCK_WORDS*4) bits.
  - index = log2(NUM_SETS) bits.
  - tag = remaining upper bits.
- Storage per line: one valid bit, one tag, BLOCK_WORDS data words. Storage is register-based with combinational read.
- The FSM has five states: IDLE, LOOKUP, AR, R, RESP.
- IDLE:
  - `req_ready`=1 unless `fence_i` is asserted or an invalidation is pending.
  - On handshake, latch the address and go to LOOKUP.
- LOOKUP:
  - Hit: `resp_valid`=1 with the addressed word; stay until `resp_ready`, then go to IDLE.
  - Miss: go to AR.
- AR:
  - `arvalid`=1, `araddr`=line base, `arsize`=2, `arburst`=INCR (2'b01), `arid`=0.
  - `arlen` is per Configuration.
  - Go to R on `arready`.
- R:
  - `rready`=1; each beat writes the word selected by the beat counter.
  - Last beat of the line: set tag; set valid only if every beat had `rresp`=OKAY. Then go to RESP.
- RESP:
  - Present the requested word (captured from the beat stream) with `resp_valid`=1.
  - `resp_err`=1 if any beat was non-OKAY.
  - Go to IDLE on `resp_ready`.
- `flush` in LOOKUP or RESP: drop `resp_valid` in that cycle and go to IDLE.
- `flush` in AR or R: set a discard flag. The refill completes and fills the line, but RESP is skipped and the FSM goes straight to IDLE.
- `fence_i` in IDLE: clear all valid bits at that clock edge.
- `fence_i` in any other state: latch as pending; apply on the first IDLE cycle. `req_ready`=0 in that cycle.
- Write channels tied off: `awvalid`=0, `wvalid`=0, `bready`=1. All other AW/W fields are 0.

## Timing
- Reset state:
  - FSM in IDLE; all valid bits, discard flag and pending-invalidate cleared.
  - `req_ready`=1 from the first cycle after reset deasserts.
  - `resp_valid`=0, `resp_inst`=0, `resp_err`=0, `arvalid`=0, `rready`=0.
- Reset mid-refill abandons the transaction; the line is not valid.
- Hit latency: `resp_valid` is asserted 1 cycle after the request handshake.
- Miss latency: 2 cycles + AR wait + beat count + memory latency.
- While `resp_valid`=1 and `resp_ready`=0, `resp_inst` and `resp_err` stay stable.
- `araddr`/`arlen` stay stable while `arvalid`=1 and `arready`=0.
- Only one AXI transaction is outstanding at any time.
- Beat counter wrap: width log2(BLOCK_WORDS); it returns to 0 after the last beat.
- Burst mode: the last beat is `rlast`; a counter mismatch with `rlast` is ignored.

## Configuration
- `YSYX_24110015_ICACHE_BURST_EN` defined:
  - One AR per miss with `arlen`=BLOCK_WORDS-1, INCR.
  - R completes on `rlast`.
- Not defined:
  - BLOCK_WORDS single-beat reads (`arlen`=0), `araddr`=base+4*i.
  - The FSM loops AR→R per word; it leaves the loop after beat BLOCK_WORDS-1.
- Functional behaviour is identical in both modes; only the AXI traffic differs.

## Structure
- Shared package `ysyx_24110015_pkg` holds:
  - AXI encodings: `AXI_BURST_INCR`, `AXI_SIZE_4B`, `AXI_RESP_OKAY`.
  - Cache state enum `icache_state_t`.
- Sub-module `ysyx_24110015_icache_array` holds tag/valid/data storage:
  - one read port (index → valid, tag, line);
  - one word-write port;
  - one tag/valid set port;
  - a global valid-clear input.

## Test plan
All scenarios use defaults, burst mode, and 1-cycle `arready`/`rvalid`.

1. Cold miss, then hit.
   - Fetch 0x3000_0000 → one AR with `araddr`=0x3000_0000, `arlen`=3. R beats return 0x11,0x22,0x33,0x44 → `resp_inst`=0x11.
   - Fetch 0x3000_0004 → `resp_inst`=0x22 one cycle after handshake, with no AR.
2. Conflict eviction: fetch 0x3000_0000, then 0x3000_0100 (same index 0) → both miss. Refetch 0x3000_0000 → miss again.
3. `fence_i` invalidation: pulse `fence_i` in IDLE after scenario 1 → `req_ready`=0 that cycle. Refetch 0x3000_0000 → AR issued.
4. `flush` during refill: assert `flush` during the R phase → no `resp_valid`. Next fetch of the same line hits.
5. Error beat: `rresp`=2'b10 on beat 2 → `resp_err`=1. Refetch → miss (line not valid).
6. Backpressure: hold `resp_ready`=0 for 5 cycles on a hit → `resp_inst` stable, and no new request accepted.
